// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the LED pong auto-player.
//   LED_W / IDX_W     : ball bar width and encoded position width
//   pa_state_t        : auto-player FSM states
//   LFSR_SEED/TAPS    : fumble LFSR constants (taps 8,6,5,4)
//   lfsr_next()       : one Fibonacci shift step
package pong_pkg;

   localparam int LED_W = 8;
   localparam int IDX_W = 3;

   typedef enum logic [2:0] {
      PA_IDLE,
      PA_SERVE,
      PA_TRACK,
      PA_REACT,
      PA_PRESS,
      PA_GAP
   } pa_state_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/pong_auto_player_onehot_pos_enc.sv
// onehot_pos_enc: combinational encoder of the LED ball bar.
//   led   in  LED_W  ball bar, expected one-hot or all-zero
//   idx   out IDX_W  index of the lowest lit LED
//   vld   out 1      exactly one LED lit
//   multi out 1      more than one LED lit
module onehot_pos_enc
   import pong_pkg::*;
(
   input  logic [LED_W-1:0] led,
   output logic [IDX_W-1:0] idx,
   output logic             vld,
   output logic             multi
);

   always_comb begin
      idx = '0;
      for (int i = LED_W-1; i >= 0; i--) begin
         if (led[i]) idx = IDX_W'(i);
      end
   end

   assign multi = ($countones(led) > 1);
   assign vld   = (led != '0) && !multi;

endmodule

// File: rtl/pong_auto_player.sv
// pong_auto_player: automatic opponent for the LED pong core.
//   Clk    in  1  system clock, rising edge
//   Rst    in  1  asynchronous active-low reset
//   Enable in  1  auto-player active
//   LedIn  in  8  ball bar from the pong core
//   Play   out 1  paddle press
//   Begin  out 1  one-cycle serve request
//   Hits   out 8  presses issued, saturating
//   Misses out 8  misses detected, saturating
//   Err    out 1  sticky: LedIn had more than one bit set
// Optional build macro AUTO_PLAYER_FUMBLE_EN: an LFSR skips roughly one
// approach in eight so the opponent occasionally misses.
module pong_auto_player
   import pong_pkg::*;
#(
   parameter int TARGET_POS   = 0,
   parameter int REACT_CYCLES = 2,
   parameter int PRESS_CYCLES = 2,
   parameter int SERVE_GAP    = 8
)
(
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Enable,
   input  logic [LED_W-1:0] LedIn,
   output logic             Play,
   output logic             Begin,
   output logic [7:0]       Hits,
   output logic [7:0]       Misses,
   output logic             Err
);

   localparam logic [IDX_W-1:0] TGT_IDX  = IDX_W'(TARGET_POS);
   localparam logic [IDX_W-1:0] APPR_IDX = IDX_W'(TARGET_POS + 1);
   localparam logic [7:0] REACT_LOAD = 8'(REACT_CYCLES - 1);
   localparam logic [7:0] PRESS_LOAD = 8'(PRESS_CYCLES - 1);
   localparam logic [7:0] GAP_LOAD   = 8'(SERVE_GAP - 1);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   pa_state_t        state, state_nx;
   logic [7:0]       cnt, cnt_nx;
   logic             hit_evt, miss_evt;
   logic [IDX_W-1:0] cur_idx;
   logic             cur_vld, cur_multi, led_zero;
   logic [IDX_W-1:0] prev_idx_p1;
   logic             prev_vld_p1, prev_zero_p1;
   logic             approach, press_go, miss_now;

   onehot_pos_enc u_enc (
      .led   (LedIn),
      .idx   (cur_idx),
      .vld   (cur_vld),
      .multi (cur_multi)
   );

   assign led_zero = (LedIn == '0);

   // ---- stage p1: previous-cycle ball position ----
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         prev_vld_p1  <= 1'b0;
         prev_zero_p1 <= 1'b0;
      end else begin
         prev_vld_p1  <= cur_vld;
         prev_zero_p1 <= led_zero;
      end
   end

   always_ff @(posedge Clk) begin
      prev_idx_p1 <= cur_idx;
   end

   // Approach is a one-step move from TARGET_POS+1 onto TARGET_POS.
   assign approach = cur_vld && (cur_idx == TGT_IDX) &&
                     prev_vld_p1 && (prev_idx_p1 == APPR_IDX);
   // Two consecutive dark samples; a single dark cycle is a glitch.
   assign miss_now = led_zero && prev_zero_p1;

`ifdef AUTO_PLAYER_FUMBLE_EN
   logic [7:0] lfsr;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) lfsr <= LFSR_SEED;
      else      lfsr <= lfsr_next(lfsr);
   end

   assign press_go = approach && (lfsr[2:0] != 3'b000);
`else
   assign press_go = approach;
`endif

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= PA_IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      hit_evt  = 1'b0;
      miss_evt = 1'b0;
      case (state)
         PA_IDLE: begin
            if (Enable) state_nx = PA_SERVE;
         end
         PA_SERVE: begin
            state_nx = Enable ? PA_TRACK : PA_IDLE;
         end
         PA_TRACK: begin
            if (!Enable) begin
               state_nx = PA_IDLE;
            end else if (miss_now) begin
               state_nx = PA_GAP;
               cnt_nx   = GAP_LOAD;
               miss_evt = 1'b1;
            end else if (press_go) begin
               if (REACT_CYCLES == 0) begin
                  state_nx = PA_PRESS;
                  cnt_nx   = PRESS_LOAD;
                  hit_evt  = 1'b1;
               end else begin
                  state_nx = PA_REACT;
                  cnt_nx   = REACT_LOAD;
               end
            end
         end
         PA_REACT: begin
            if (!Enable) begin
               state_nx = PA_IDLE;
            end else if (miss_now) begin
               state_nx = PA_GAP;
               cnt_nx   = GAP_LOAD;
               miss_evt = 1'b1;
            end else if (cnt == 8'd0) begin
               state_nx = PA_PRESS;
               cnt_nx   = PRESS_LOAD;
               hit_evt  = 1'b1;
            end else begin
               cnt_nx = cnt - 8'd1;
            end
         end
         PA_PRESS: begin
            // A press always runs its full width, even if Enable drops.
            if (cnt == 8'd0) state_nx = Enable ? PA_TRACK : PA_IDLE;
            else             cnt_nx   = cnt - 8'd1;
         end
         PA_GAP: begin
            if (!Enable)            state_nx = PA_IDLE;
            else if (cnt == 8'd0)   state_nx = PA_SERVE;
            else                    cnt_nx   = cnt - 8'd1;
         end
         default: state_nx = PA_IDLE;
      endcase
   end

   always_comb begin
      Play  = 1'b0;
      Begin = 1'b0;
      if (state == PA_PRESS) Play  = 1'b1;
      if (state == PA_SERVE) Begin = 1'b1;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         Hits   <= 8'd0;
         Misses <= 8'd0;
         Err    <= 1'b0;
      end else begin
         if (hit_evt)   Hits   <= sat_inc(Hits);
         if (miss_evt)  Misses <= sat_inc(Misses);
         if (cur_multi) Err    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pong_auto_player.sv
module tb_pong_auto_player;

   logic       Clk;
   logic       Rst;
   logic       en_a, en_b;
   logic [7:0] led_a, led_b;
   logic       play_a, begin_a, err_a;
   logic       play_b, begin_b, err_b;
   logic [7:0] hits_a, misses_a, hits_b, misses_b;

   int n_tests = 0;
   int n_fail  = 0;
   logic ovl_a = 1'b0;
   logic ovl_b = 1'b0;

   pong_auto_player u_dut_a (
      .Clk    (Clk),
      .Rst    (Rst),
      .Enable (en_a),
      .LedIn  (led_a),
      .Play   (play_a),
      .Begin  (begin_a),
      .Hits   (hits_a),
      .Misses (misses_a),
      .Err    (err_a)
   );

   pong_auto_player #(
      .TARGET_POS   (0),
      .REACT_CYCLES (0),
      .PRESS_CYCLES (1),
      .SERVE_GAP    (1)
   ) u_dut_b (
      .Clk    (Clk),
      .Rst    (Rst),
      .Enable (en_b),
      .LedIn  (led_b),
      .Play   (play_b),
      .Begin  (begin_b),
      .Hits   (hits_b),
      .Misses (misses_b),
      .Err    (err_b)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (play_a && begin_a) ovl_a <= 1'b1;
      if (play_b && begin_b) ovl_b <= 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge Clk);
         #1;
      end
   endtask

   initial begin
      Rst = 1'b0; en_a = 1'b0; en_b = 1'b0; led_a = 8'h00; led_b = 8'h00;
      tick(3);
      chk("rst_play",   play_a,   1'b0);
      chk("rst_begin",  begin_a,  1'b0);
      chk("rst_hits",   hits_a,   8'd0);
      chk("rst_misses", misses_a, 8'd0);
      chk("rst_err",    err_a,    1'b0);
      Rst = 1'b1;
      tick();
      en_a = 1'b1;

      // serve
      tick();
      chk("serve_begin", begin_a, 1'b1);
      chk("serve_play",  play_a,  1'b0);
      tick();
      chk("serve_begin_1cyc", begin_a, 1'b0);
      chk("serve_hits", hits_a, 8'd0);
      led_a = 8'h04;

      // approach 04 -> 02 -> 01, press on 3rd and 4th cycle after 01
      tick(); led_a = 8'h02;
      tick(); led_a = 8'h01;
      tick(); chk("react_play0", play_a, 1'b0);
      tick(); chk("react_play1", play_a, 1'b0);
      tick(); chk("press_play0", play_a, 1'b1);
      chk("press_hits", hits_a, 8'd1);
      tick(); chk("press_play1", play_a, 1'b1);
      tick(); chk("press_end",   play_a, 1'b0);

      // single dark cycle is ignored
      led_a = 8'h00;
      tick(); led_a = 8'h01;
      tick(); chk("glitch_nomiss", misses_a, 8'd0);

      // multi-bit bar sets sticky Err
      led_a = 8'h18;
      tick(); chk("err_set", err_a, 1'b1);
      led_a = 8'h01;
      tick(3);
      chk("err_sticky", err_a, 1'b1);
      chk("err_noplay", play_a, 1'b0);

      // miss, then 8 gap cycles, then Begin
      led_a = 8'h00;
      tick(); chk("miss_first_zero", misses_a, 8'd0);
      tick(); chk("miss_count", misses_a, 8'd1);
      chk("miss_nobegin", begin_a, 1'b0);
      tick(7); chk("gap_nobegin", begin_a, 1'b0);
      tick();  chk("gap_begin", begin_a, 1'b1);
      led_a = 8'h04;
      tick();  chk("gap_begin_1cyc", begin_a, 1'b0);

      // Enable drops mid-press: press completes then IDLE
      led_a = 8'h02;
      tick(); led_a = 8'h01;
      tick(); tick(); tick();
      chk("en_press_play", play_a, 1'b1);
      chk("en_press_hits", hits_a, 8'd2);
      en_a = 1'b0;
      tick(); chk("en_press_holds", play_a, 1'b1);
      tick(); chk("en_press_done",  play_a, 1'b0);
      tick(3);
      chk("en_idle_nobegin", begin_a, 1'b0);
      chk("en_idle_noplay",  play_a,  1'b0);
      en_a = 1'b1;
      tick(); chk("reen_begin", begin_a, 1'b1);
      tick();
      led_a = 8'h02;
      tick(); led_a = 8'h01;
      tick(); tick(); tick();
      chk("reen_press", play_a, 1'b1);
      chk("reen_hits",  hits_a, 8'd3);

      // async reset mid-press
      Rst = 1'b0;
      #1;
      chk("arst_play",   play_a,   1'b0);
      chk("arst_hits",   hits_a,   8'd0);
      chk("arst_misses", misses_a, 8'd0);
      chk("arst_err",    err_a,    1'b0);
      tick();
      Rst = 1'b1; en_a = 1'b0;
      tick();

      // REACT_CYCLES=0 instance
      en_b = 1'b1;
      tick(); chk("b_serve", begin_b, 1'b1);
      led_b = 8'h02;
      tick(); led_b = 8'h01;
      tick(); chk("b_press_next", play_b, 1'b1);
      chk("b_hits", hits_b, 8'd1);
      tick(); chk("b_press_1cyc", play_b, 1'b0);
      led_b = 8'h02;
      tick(); chk("b_recede0", play_b, 1'b0);
      led_b = 8'h04;
      tick(); chk("b_recede1", play_b, 1'b0);
      chk("b_recede_hits", hits_b, 8'd1);

      // saturating misses
      led_b = 8'h00;
      tick(900);
      chk("b_miss_sat", misses_b, 8'hFF);
      chk("b_miss_sat_hits", hits_b, 8'd1);

      // saturating hits
      for (int k = 0; k < 700; k++) begin
         led_b = k[0] ? 8'h01 : 8'h02;
         tick();
      end
      chk("b_hit_sat", hits_b, 8'hFF);
      chk("b_hit_sat_misses", misses_b, 8'hFF);
      chk("b_err_clean", err_b, 1'b0);

      chk("a_play_begin_excl", ovl_a, 1'b0);
      chk("b_play_begin_excl", ovl_b, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
